// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings, response constants and slave FSM states.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package ahb_sram_slave_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_t;

    // Little-endian byte-lane enables for a transfer of the given size at
    // the given low address bits. Unsupported sizes select no lanes.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << a;
            HSIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: m = 4'b1111;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between one master (or interconnect) and the SRAM slave.
// Latency: n/a (wires only).
// Backpressure: HREADYOUT from the slave, HREADY as the bus-wide ready.
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_sram_slave_sram_byte_array.sv
// DEPTH_WORDS x 32 storage with four independent byte-write enables.
// Latency: write on rising CLK, read combinational from addr.
// Backpressure: none; always ready. Ports: CLK, addr, we[3:0], wdata, rdata.
module sram_byte_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          CLK,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    // One array per byte lane so each lane maps onto a plain RAM macro.
    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];

        always_ff @(posedge CLK) begin
            if (we[b]) begin
                mem[addr] <= wdata[8*b +: 8];
            end
        end

        assign rdata[8*b +: 8] = mem[addr];
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-organised SRAM slave with programmable wait states and ERROR responses.
// Latency: OKAY data phase 1+WAIT_STATES cycles; ERROR data phase exactly 2 cycles.
// Backpressure: HREADYOUT low during wait states and ERR1; next address phase taken in the ready cycle.
// Ports: CLK, nRST (async active-low), bus (slave modport: HSEL/HADDR/HTRANS/HWRITE/HSIZE/
//        HWDATA/HREADY in, HRDATA/HREADYOUT/HRESP out).
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic               CLK,
    input  logic               nRST,
    ahb_sram_slave_if.slave    bus
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN    = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    slv_state_t    state;
    logic          hreadyout_q;
    logic          hresp_q;
    logic          act_q;       // an OKAY data phase is in progress
    logic          write_q;
    logic [AW-1:0] word_q;
    logic [3:0]    be_q;
    logic [3:0]    wcnt_q;

    logic [31:0]   off;
    logic          accept;
    logic          acc_err;
    logic          done;
    logic [3:0]    mem_we;
    logic [31:0]   mem_rdata;

    assign off    = bus.HADDR - BASE_ADDR;
    assign accept = bus.HSEL & bus.HREADY &
                    ((bus.HTRANS == HTRANS_NONSEQ) | (bus.HTRANS == HTRANS_SEQ));

    // Addresses below BASE_ADDR wrap to huge offsets and land in the range error too.
    assign acc_err = ({1'b0, off} >= SPAN)
                   | (bus.HSIZE >= 3'd3)
                   | ((bus.HSIZE == HSIZE_HALF) & off[0])
                   | ((bus.HSIZE == HSIZE_WORD) & (off[1:0] != 2'b00));

    // Final cycle of an OKAY data phase: write commits on the closing edge,
    // read data is presented during the cycle.
    assign done   = act_q & hreadyout_q;
    assign mem_we = {4{done & write_q}} & be_q;

    assign bus.HRDATA    = (done & ~write_q) ? mem_rdata : 32'h0;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            act_q       <= 1'b0;
            write_q     <= 1'b0;
            word_q      <= '0;
            be_q        <= 4'b0000;
            wcnt_q      <= 4'd0;
        end else if (hreadyout_q) begin
            // Ready cycle (idle, DONE or ERR2): the current data phase ends
            // here and the next address phase may be captured.
            if (accept) begin
                write_q <= bus.HWRITE;
                word_q  <= off[AW+1:2];
                be_q    <= lane_mask(bus.HSIZE, off[1:0]);
                if (acc_err) begin
                    state       <= ST_ERR1;
                    hreadyout_q <= 1'b0;
                    hresp_q     <= HRESP_ERROR;
                    act_q       <= 1'b0;
                end else if (WAIT_STATES == 0) begin
                    state       <= ST_IDLE;
                    hresp_q     <= HRESP_OKAY;
                    act_q       <= 1'b1;
                end else begin
                    state       <= ST_WAIT;
                    hreadyout_q <= 1'b0;
                    hresp_q     <= HRESP_OKAY;
                    act_q       <= 1'b1;
                    wcnt_q      <= WS_LOAD;
                end
            end else begin
                state   <= ST_IDLE;
                hresp_q <= HRESP_OKAY;
                act_q   <= 1'b0;
            end
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wcnt_q == 4'd0) begin
                        state       <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                end
                default: begin
                    state       <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                    act_q       <= 1'b0;
                end
            endcase
        end
    end

    sram_byte_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem (
        .CLK   (CLK),
        .addr  (word_q),
        .we    (mem_we),
        .wdata (bus.HWDATA),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: three instances (0, 3 and 5 wait states)
// share one pipelined AHB driver; a negedge monitor pops expected responses.
module tb_ahb_sram_slave;
    import ahb_sram_slave_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    logic        hsel;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [1:0]  dut_sel;

    logic [2:0]  rdy_v;
    logic [2:0]  resp_v;
    logic [31:0] rdata_v [3];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        ahb_sram_slave_if bus_i ();

        assign bus_i.HSEL   = hsel & (dut_sel == 2'(k));
        assign bus_i.HADDR  = haddr;
        assign bus_i.HTRANS = htrans;
        assign bus_i.HWRITE = hwrite;
        assign bus_i.HSIZE  = hsize;
        assign bus_i.HWDATA = hwdata;
        assign bus_i.HREADY = bus_i.HREADYOUT;
        assign rdy_v[k]     = bus_i.HREADYOUT;
        assign resp_v[k]    = bus_i.HRESP;
        assign rdata_v[k]   = bus_i.HRDATA;

        ahb_sram_slave #(
            .BASE_ADDR   (32'h0000_0000),
            .DEPTH_WORDS (1024),
            .WAIT_STATES ((k == 0) ? 0 : ((k == 1) ? 3 : 5))
        ) u_dut (
            .CLK  (CLK),
            .nRST (nRST),
            .bus  (bus_i.slave)
        );
    end

    logic        m_ready;
    logic        m_resp;
    logic [31:0] m_rdata;
    assign m_ready = rdy_v[dut_sel];
    assign m_resp  = resp_v[dut_sel];
    assign m_rdata = rdata_v[dut_sel];

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        resp;
        int          waits;
    } exp_t;

    exp_t        expq[$];
    int          checks  = 0;
    int          errors  = 0;
    int          beat_id = 0;
    int          lowcnt  = 0;
    int          lowresp = 0;
    logic [31:0] pend_wd;

    task automatic check(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s beat=%0d got=%h want=%h", nm, id, got, want);
        end
    endtask

    // Monitor: count not-ready cycles of the current data phase, and compare
    // against the oldest expectation when a ready cycle closes it.
    always @(negedge CLK) begin
        exp_t e;
        if (!nRST) begin
            lowcnt  = 0;
            lowresp = 0;
        end else if (!m_ready) begin
            lowcnt++;
            if (m_resp) lowresp++;
        end else begin
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("hresp",        e.id, 32'(m_resp),  32'(e.resp));
                check("hrdata",       e.id, m_rdata,      e.rdata);
                check("wait_cycles",  e.id, 32'(lowcnt),  32'(e.waits));
                check("err_low_resp", e.id, 32'(lowresp), e.resp ? 32'd1 : 32'd0);
            end
            lowcnt  = 0;
            lowresp = 0;
        end
    end

    // Wait for the edge that accepts the address phase currently driven.
    task automatic wait_ready();
        int   n;
        logic r;
        n = 0;
        do begin
            @(negedge CLK);
            r = m_ready;
            @(posedge CLK);
            n++;
        end while (!r && n < 64);
        check("accept_timeout", beat_id + 1, 32'(r), 32'd1);
        #1;
    endtask

    // One pipelined beat: drives its address phase together with the previous
    // beat's write data, then queues the expected data-phase response.
    task automatic beat(input logic s, input logic [1:0] tr, input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] wd, input logic [31:0] er,
                        input logic eresp, input int ew);
        exp_t e;
        hsel   = s;
        htrans = tr;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        hwdata = pend_wd;
        wait_ready();
        pend_wd = wd;
        beat_id++;
        e.id    = beat_id;
        e.rdata = er;
        e.resp  = eresp;
        e.waits = ew;
        expq.push_back(e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d, input int ew);
        beat(1'b1, HTRANS_NONSEQ, a, 1'b1, sz, d, 32'h0, HRESP_OKAY, ew);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input int ew);
        beat(1'b1, HTRANS_NONSEQ, a, 1'b0, HSIZE_WORD, 32'h0, d, HRESP_OKAY, ew);
    endtask

    task automatic er(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] d);
        beat(1'b1, HTRANS_NONSEQ, a, w, sz, d, 32'h0, HRESP_ERROR, 1);
    endtask

    task automatic idle();
        beat(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 32'h0, HRESP_OKAY, 0);
    endtask

    initial begin
        nRST    = 1'b0;
        hsel    = 1'b0;
        htrans  = HTRANS_IDLE;
        haddr   = 32'h0;
        hwrite  = 1'b0;
        hsize   = HSIZE_WORD;
        hwdata  = 32'h0;
        dut_sel = 2'd0;
        pend_wd = 32'h0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        for (int s = 0; s < 3; s++) begin
            dut_sel = 2'(s);
            #1;
            check("rst_hreadyout", s, 32'(m_ready), 32'd1);
            check("rst_hresp",     s, 32'(m_resp),  32'd0);
            check("rst_hrdata",    s, m_rdata,      32'h0);
        end
        dut_sel = 2'd0;
        @(posedge CLK);
        #1 nRST = 1'b1;

        // Zero wait states: back-to-back write then read of the same word.
        wr(32'h10, HSIZE_WORD, 32'hDEADBEEF, 0);
        rd(32'h10, 32'hDEADBEEF, 0);

        // Byte and halfword merges into a word.
        wr(32'h20, HSIZE_WORD, 32'h11223344, 0);
        wr(32'h21, HSIZE_BYTE, 32'hAAAAAAAA, 0);
        wr(32'h22, HSIZE_HALF, 32'hBBCCBBCC, 0);
        rd(32'h20, 32'hBBCCAA44, 0);

        // Errors: out of range, misaligned, oversize; writes around them.
        er(32'h1000, 1'b0, HSIZE_WORD, 32'h0);
        wr(32'h30, HSIZE_WORD, 32'h55667788, 0);
        er(32'h12, 1'b1, HSIZE_WORD, 32'h0BADF00D);
        rd(32'h10, 32'hDEADBEEF, 0);
        rd(32'h30, 32'h55667788, 0);
        er(32'h2, 1'b0, HSIZE_WORD, 32'h0);
        er(32'h23, 1'b0, HSIZE_HALF, 32'h0);
        er(32'h20, 1'b0, 3'd3, 32'h0);
        rd(32'h20, 32'hBBCCAA44, 0);
        wr(32'hFFC, HSIZE_WORD, 32'hA5A55A5A, 0);
        rd(32'hFFC, 32'hA5A55A5A, 0);

        // Burst of 4 interleaved with BUSY, IDLE and deselected phases aimed at 0x50.
        wr(32'h50, HSIZE_WORD, 32'h5A5A5A5A, 0);
        beat(1'b1, HTRANS_NONSEQ, 32'h40, 1'b1, HSIZE_WORD, 32'h01010101, 32'h0, HRESP_OKAY, 0);
        beat(1'b1, HTRANS_BUSY,   32'h50, 1'b1, HSIZE_WORD, 32'hFFFFFFFF, 32'h0, HRESP_OKAY, 0);
        beat(1'b1, HTRANS_SEQ,    32'h44, 1'b1, HSIZE_WORD, 32'h02020202, 32'h0, HRESP_OKAY, 0);
        beat(1'b0, HTRANS_NONSEQ, 32'h50, 1'b1, HSIZE_WORD, 32'hFFFFFFFF, 32'h0, HRESP_OKAY, 0);
        beat(1'b1, HTRANS_SEQ,    32'h48, 1'b1, HSIZE_WORD, 32'h03030303, 32'h0, HRESP_OKAY, 0);
        beat(1'b1, HTRANS_IDLE,   32'h50, 1'b1, HSIZE_WORD, 32'hFFFFFFFF, 32'h0, HRESP_OKAY, 0);
        beat(1'b1, HTRANS_SEQ,    32'h4C, 1'b1, HSIZE_WORD, 32'h04040404, 32'h0, HRESP_OKAY, 0);
        rd(32'h40, 32'h01010101, 0);
        rd(32'h44, 32'h02020202, 0);
        rd(32'h48, 32'h03030303, 0);
        rd(32'h4C, 32'h04040404, 0);
        rd(32'h50, 32'h5A5A5A5A, 0);
        idle();
        idle();

        // Three wait states; error length is unaffected.
        dut_sel = 2'd1;
        wr(32'h4, HSIZE_WORD, 32'h0F0F0F0F, 3);
        rd(32'h4, 32'h0F0F0F0F, 3);
        er(32'h1004, 1'b0, HSIZE_WORD, 32'h0);
        rd(32'h4, 32'h0F0F0F0F, 3);
        idle();
        idle();

        // Five wait states: reset in the middle of a write's wait.
        dut_sel = 2'd2;
        wr(32'h40, HSIZE_WORD, 32'h12345678, 5);
        idle();
        wr(32'h40, HSIZE_WORD, 32'hCAFEF00D, 5);
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwdata = pend_wd;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b0;
        expq.delete();
        @(negedge CLK);
        check("midwait_rst_hreadyout", beat_id, 32'(m_ready), 32'd1);
        check("midwait_rst_hresp",     beat_id, 32'(m_resp),  32'd0);
        check("midwait_rst_hrdata",    beat_id, m_rdata,      32'h0);
        @(posedge CLK);
        #1;
        nRST    = 1'b1;
        pend_wd = 32'h0;
        rd(32'h40, 32'h12345678, 5);
        idle();
        idle();

        repeat (4) @(posedge CLK);
        check("queue_drain", beat_id, 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
